// File: rtl/imem_run_ctrl_if.sv
// imem_run_ctrl_if
//   Bundles the single instruction-memory port with the fetch-stage
//   request/return path so that both travel as one bus between the
//   run controller and its environment (memory macro + fetch stage).
//
// Handshake semantics (fetch side):
//   fetch_req is a level request from the fetch stage. A request counts as
//   accepted only in a cycle where fetch_grant is high. Each accepted request
//   returns exactly one word: fetch_valid is high in the following cycle, and
//   fetch_instr holds the word in that cycle. A cycle with fetch_req high but
//   no fetch_grant is a bubble. The fetch stage holds its PC and retries.
//
// Signals:
//   mem_en/mem_we/mem_addr/mem_wdata : controller -> memory port
//   mem_rdata                        : memory -> controller, 1 cycle read latency
//   fetch_req/fetch_addr             : fetch stage -> controller
//   fetch_grant/fetch_valid/fetch_instr : controller -> fetch stage
// Modports:
//   master : run controller side
//   slave  : environment side (memory and fetch stage)
interface imem_run_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_grant;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    input  fetch_req, fetch_addr,
    output fetch_grant, fetch_valid, fetch_instr
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    output fetch_req, fetch_addr,
    input  fetch_grant, fetch_valid, fetch_instr
  );
endinterface

// File: rtl/imem_run_ctrl.sv
// imem_run_ctrl
//   Run controller and port arbiter for the CPU's single-port synchronous
//   instruction memory. Sequences IDLE -> LOAD -> IDLE -> RUN, and shares the
//   memory port between external instruction writes and CPU fetch reads.
//   External writes always win the port. Fetch reads are only served in RUN.
//
// Ports:
//   clk                 : system clock, rising edge
//   rst                 : asynchronous active-low reset
//   start               : global run request (level)
//   I_MEM_Write_Enable  : external instruction write strobe
//   I_MEM_Write_Addr    : external write address
//   I_MEM_Data_In       : external write data
//   bus                 : memory port + fetch path (imem_run_ctrl_if.master)
//   cpu_en              : high only in RUN (registered)
//   load_count          : writes accepted since last IDLE->LOAD, saturating
//   cycle_count         : cycles spent in RUN since last IDLE->RUN, wrapping
//   state               : FSM state, IDLE=0 LOAD=1 RUN=2
module imem_run_ctrl #(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] NOOP   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                I_MEM_Write_Enable,
  input  logic [ADDR_W-1:0]   I_MEM_Write_Addr,
  input  logic [DATA_W-1:0]   I_MEM_Data_In,
  imem_run_ctrl_if.master     bus,
  output logic                cpu_en,
  output logic [ADDR_W:0]     load_count,
  output logic [31:0]         cycle_count,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LOAD_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LOAD_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t cur_state;
  state_t nxt_state;
  logic   wr_go;
  logic   rd_go;
  logic   fetch_valid_q;

  assign state = cur_state;

  // One access per cycle: a write steals the port even from a RUN fetch.
  assign wr_go = I_MEM_Write_Enable;
  assign rd_go = (cur_state == RUN) && bus.fetch_req && !I_MEM_Write_Enable;

  // Port drive is forced quiet while rst is asserted.
  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.fetch_grant = 1'b0;
    if (rst) begin
      if (wr_go) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = I_MEM_Write_Addr;
        bus.mem_wdata = I_MEM_Data_In;
      end else if (rd_go) begin
        bus.mem_en      = 1'b1;
        bus.mem_addr    = bus.fetch_addr;
        bus.fetch_grant = 1'b1;
      end
    end
  end

  // Write has priority over start in IDLE. start is ignored while loading.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (I_MEM_Write_Enable) nxt_state = LOAD;
        else if (start)         nxt_state = RUN;
      end
      LOAD: if (!I_MEM_Write_Enable) nxt_state = IDLE;
      RUN:  if (!start)              nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state     <= IDLE;
      cpu_en        <= 1'b0;
      fetch_valid_q <= 1'b0;
      load_count    <= '0;
      cycle_count   <= '0;
    end else begin
      cur_state     <= nxt_state;
      cpu_en        <= (nxt_state == RUN);
      fetch_valid_q <= rd_go;

      // The write that triggers IDLE->LOAD is itself the first one counted.
      if ((cur_state == IDLE) && (nxt_state == LOAD))
        load_count <= LOAD_ONE;
      else if (wr_go && (load_count != LOAD_MAX))
        load_count <= load_count + LOAD_ONE;

      if ((cur_state == IDLE) && (nxt_state == RUN))
        cycle_count <= '0;
      else if (cur_state == RUN)
        cycle_count <= cycle_count + 32'd1;
    end
  end

  // The memory's own output register holds the word read in the grant cycle,
  // so the returned instruction is that register qualified by the registered
  // valid flag. A bubble or reset shows NOOP.
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_instr = fetch_valid_q ? bus.mem_rdata : NOOP;

endmodule

// File: tb/tb_imem_run_ctrl.sv
// tb_imem_run_ctrl
//   Directed bench for imem_run_ctrl. A small synchronous memory model
//   (1-cycle read latency) sits on the slave side of the bus. Inputs change
//   1 time unit after the rising edge. Outputs are sampled there as well.
module tb_imem_run_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_en;
  logic [ADDR_W:0]   load_count;
  logic [31:0]       cycle_count;
  logic [1:0]        state;

  int checks;
  int errors;

  imem_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOOP(32'h0000_0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .I_MEM_Write_Enable (wr_en),
    .I_MEM_Write_Addr   (wr_addr),
    .I_MEM_Data_In      (wr_data),
    .bus                (bus),
    .cpu_en             (cpu_en),
    .load_count         (load_count),
    .cycle_count        (cycle_count),
    .state              (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction memory model
  logic [DATA_W-1:0] mem_arr [0:63];
  logic [DATA_W-1:0] rdata_q;
  initial rdata_q = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr[5:0]] <= bus.mem_wdata;
      else            rdata_q <= mem_arr[bus.mem_addr[5:0]];
    end
  end
  assign bus.mem_rdata = rdata_q;

  function automatic logic [31:0] word_of(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'hC821_0005;
      2:       return 32'hC842_000A;
      default: return 32'h1000_0000 + i;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    wr_en = 1'b1;
    wr_addr = 16'h0005;
    wr_data = 32'h1234_5678;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;

    // reset state, with a write strobe present to show the port stays quiet
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_fvalid", 32'(bus.fetch_valid), 32'd0);
    check("rst_finstr", bus.fetch_instr, 32'h0);
    check("rst_load_cnt", 32'(load_count), 32'd0);
    check("rst_cycle_cnt", cycle_count, 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    wr_en = 1'b0;
    tick();
    rst = 1'b1;

    // load 27 words at addresses 0..26
    wr_en = 1'b1;
    for (int i = 0; i < 27; i++) begin
      wr_addr = 16'(i);
      wr_data = word_of(i);
      #1;
      check($sformatf("ld_mem_we_%0d", i), 32'(bus.mem_we), 32'd1);
      check($sformatf("ld_mem_addr_%0d", i), 32'(bus.mem_addr), i);
      check($sformatf("ld_mem_wdata_%0d", i), bus.mem_wdata, word_of(i));
      tick();
      check($sformatf("ld_state_%0d", i), 32'(state), 32'd1);
      check($sformatf("ld_cpu_en_%0d", i), 32'(cpu_en), 32'd0);
      check($sformatf("ld_count_%0d", i), 32'(load_count), i + 1);
    end
    wr_en = 1'b0;
    #1;
    check("ld_end_mem_en", 32'(bus.mem_en), 32'd0);
    check("ld_end_state", 32'(state), 32'd1);
    tick();
    check("ld_idle_state", 32'(state), 32'd0);
    check("ld_idle_count", 32'(load_count), 32'd27);

    // start and fetch words 0,1,2
    start = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 16'd0;
    #1;
    check("idle_no_grant", 32'(bus.fetch_grant), 32'd0);
    tick();
    check("run_state", 32'(state), 32'd2);
    check("run_cpu_en", 32'(cpu_en), 32'd1);
    check("run_cycle0", cycle_count, 32'd0);
    check("run_fvalid0", 32'(bus.fetch_valid), 32'd0);
    #1;
    check("run_grant", 32'(bus.fetch_grant), 32'd1);
    check("run_rd_we", 32'(bus.mem_we), 32'd0);
    check("run_rd_en", 32'(bus.mem_en), 32'd1);
    tick();
    check("f0_valid", 32'(bus.fetch_valid), 32'd1);
    check("f0_instr", bus.fetch_instr, 32'h0000_0000);
    check("f0_cycle", cycle_count, 32'd1);
    bus.fetch_addr = 16'd1;
    tick();
    check("f1_valid", 32'(bus.fetch_valid), 32'd1);
    check("f1_instr", bus.fetch_instr, 32'hC821_0005);
    bus.fetch_addr = 16'd2;
    tick();
    check("f2_valid", 32'(bus.fetch_valid), 32'd1);
    check("f2_instr", bus.fetch_instr, 32'hC842_000A);
    check("f2_cycle", cycle_count, 32'd3);

    // write during RUN steals the port from a fetch
    bus.fetch_addr = 16'd3;
    wr_en = 1'b1;
    wr_addr = 16'd30;
    wr_data = 32'hDEAD_0030;
    #1;
    check("rw_grant", 32'(bus.fetch_grant), 32'd0);
    check("rw_mem_we", 32'(bus.mem_we), 32'd1);
    check("rw_mem_addr", 32'(bus.mem_addr), 32'd30);
    tick();
    wr_en = 1'b0;
    check("rw_state", 32'(state), 32'd2);
    check("rw_fvalid", 32'(bus.fetch_valid), 32'd0);
    check("rw_finstr", bus.fetch_instr, 32'h0);
    check("rw_load_cnt", 32'(load_count), 32'd28);
    check("rw_cycle", cycle_count, 32'd4);

    // drop start with a fetch granted in the same cycle
    bus.fetch_addr = 16'd1;
    start = 1'b0;
    #1;
    check("ds_grant", 32'(bus.fetch_grant), 32'd1);
    tick();
    check("ds_state", 32'(state), 32'd0);
    check("ds_cpu_en", 32'(cpu_en), 32'd0);
    check("ds_fvalid", 32'(bus.fetch_valid), 32'd1);
    check("ds_finstr", bus.fetch_instr, 32'hC821_0005);
    check("ds_cycle", cycle_count, 32'd5);
    #1;
    check("ds_no_grant", 32'(bus.fetch_grant), 32'd0);
    check("ds_mem_en", 32'(bus.mem_en), 32'd0);
    tick();
    check("ds2_state", 32'(state), 32'd0);
    check("ds2_fvalid", 32'(bus.fetch_valid), 32'd0);
    check("ds2_cycle", cycle_count, 32'd5);

    // start and write together in IDLE: write wins, RUN after the write ends
    bus.fetch_req = 1'b0;
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = 16'd31;
    wr_data = 32'hBEEF_0031;
    tick();
    check("sw_state_load", 32'(state), 32'd1);
    check("sw_load_cnt", 32'(load_count), 32'd1);
    check("sw_cpu_en", 32'(cpu_en), 32'd0);
    wr_en = 1'b0;
    tick();
    check("sw_state_idle", 32'(state), 32'd0);
    tick();
    check("sw_state_run", 32'(state), 32'd2);
    check("sw_cpu_en_run", 32'(cpu_en), 32'd1);
    check("sw_cycle", cycle_count, 32'd0);
    check("sw_load_hold", 32'(load_count), 32'd1);

    // read back the word written during RUN, then reset with a fetch in flight
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 16'd30;
    tick();
    check("rb_valid", 32'(bus.fetch_valid), 32'd1);
    check("rb_instr", bus.fetch_instr, 32'hDEAD_0030);
    check("rb_cycle", cycle_count, 32'd1);
    check("rb_grant", 32'(bus.fetch_grant), 32'd1);
    rst = 1'b0;
    #1;
    check("mr_state", 32'(state), 32'd0);
    check("mr_cpu_en", 32'(cpu_en), 32'd0);
    check("mr_fvalid", 32'(bus.fetch_valid), 32'd0);
    check("mr_finstr", bus.fetch_instr, 32'h0);
    check("mr_load_cnt", 32'(load_count), 32'd0);
    check("mr_cycle", cycle_count, 32'd0);
    check("mr_mem_en", 32'(bus.mem_en), 32'd0);
    check("mr_grant", 32'(bus.fetch_grant), 32'd0);
    tick();
    check("mr2_fvalid", 32'(bus.fetch_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
